rx_bb_gain_ctrl: RTL and testbench

Automatic digital-gain controller for the RX sample path in the `acc_clk` domain.
- Monitors the pre-gain 4-lane I/Q samples popped from the ADC clock-crossing FIFO and measures peak magnitude over fixed windows.
- Drives the 3-bit left-shift `bb_gain` select (0..4) consumed by the ADC interface, with fast attack and hysteretic slow release.
- Holds gain stable while the receiver is mid-packet.

---
 rtl/rx_bb_gain_pkg.sv | 26 ++
 rtl/rx_gain_peak_det.sv | 45 ++++
 rtl/rx_bb_gain_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rx_bb_gain_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rx_bb_gain_pkg.sv
// Shared definitions for the RX baseband digital-gain controller.
//   state_t    : controller states (IDLE, MEASURE, DECIDE, FROZEN)
//   MAX_GAIN   : largest legal bb_gain shift select
//   clamp_gain : limits a 3-bit gain request to 0..MAX_GAIN
package rx_bb_gain_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_GAIN = 3'd4;

  function automatic logic [2:0] clamp_gain(input logic [2:0] gain);
    logic [2:0] res;
    if (gain > MAX_GAIN) begin
      res = MAX_GAIN;
    end else begin
      res = gain;
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_gain_peak_det.sv
// Combinational 4-lane peak-magnitude detector.
//   sample : 4 packed signed lanes, lane i at [i*W +: W]
//   peak   : max over lanes of |x|; the most negative code saturates to
//            the largest positive code so the result always fits in W bits
module rx_gain_peak_det #(
  parameter int IQ_DATA_WIDTH = 16
) (
  input  logic [4*IQ_DATA_WIDTH-1:0] sample,
  output logic [IQ_DATA_WIDTH-1:0]   peak
);
  import rx_bb_gain_pkg::*;

  localparam int W = IQ_DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
    logic [W-1:0] res;
    if (x == MOST_NEG) begin
      res = MOST_POS;
    end else if (x[W-1]) begin
      res = ~x + ONE;
    end else begin
      res = x;
    end
    return res;
  endfunction

  // Running max of the saturated lane magnitudes.
  always_comb begin
    logic [W-1:0] mag;
    peak = '0;
    mag  = '0;
    for (int i = 0; i < 4; i++) begin
      mag = abs_sat(sample[i*W +: W]);
      if (mag > peak) begin
        peak = mag;
      end else begin
        peak = peak;
      end
    end
  end

endmodule

// File: rtl/rx_bb_gain_ctrl.sv
// Automatic digital-gain controller for the RX sample path.
//   acc_clk/acc_rst : clock, async active-high reset
//   enable          : 1 = automatic gain, 0 = manual_gain (clamped to 0..4)
//   freeze          : holds the committed gain while a packet is in flight
//   sample_in/valid : pre-gain 4-lane samples popped from the ADC FIFO
//   overload_clr    : clears the sticky overload flag (a same-cycle set wins)
//   bb_gain         : registered left-shift select, 0..4
//   gain_change     : one-cycle pulse when auto mode changes bb_gain
//   peak_last       : peak magnitude of the last completed window
//   overload        : sticky full-scale indicator
// Peaks are gathered over 2^WIN_LOG2 accepted samples; one DECIDE cycle then
// drops the gain straight to the best fit, or raises it by one step only
// after UP_HOLD consecutive windows ask for more.
module rx_bb_gain_ctrl #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int WIN_LOG2      = 6,
  parameter int TARGET_MSB    = 14,
  parameter int UP_HOLD       = 4
) (
  input  logic                       acc_clk,
  input  logic                       acc_rst,
  input  logic                       enable,
  input  logic [2:0]                 manual_gain,
  input  logic                       freeze,
  input  logic [4*IQ_DATA_WIDTH-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       overload_clr,
  output logic [2:0]                 bb_gain,
  output logic                       gain_change,
  output logic [IQ_DATA_WIDTH-1:0]   peak_last,
  output logic                       overload
);
  import rx_bb_gain_pkg::*;

  localparam int W   = IQ_DATA_WIDTH;
  localparam int UPW = $clog2(UP_HOLD) + 1;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0] CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [UPW-1:0]      UP_LAST  = UPW'(UP_HOLD - 1);
  localparam logic [UPW-1:0]      UP_ONE   = {{(UPW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]        FULL     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W+3:0]        TARGET_LIM = {{(W+3){1'b0}}, 1'b1} << TARGET_MSB;

  state_t              state_r, state_n;
  logic [2:0]          bb_gain_r, bb_gain_n;
  logic                gain_change_r, gain_change_n;
  logic [W-1:0]        peak_last_r, peak_last_n;
  logic                overload_r, overload_n;
  logic [W-1:0]        acc_r, acc_n;
  logic [WIN_LOG2-1:0] cnt_r, cnt_n;
  logic [UPW-1:0]      up_cnt_r, up_cnt_n;
  logic [W-1:0]        peak_s;
  logic [W-1:0]        acc_max_s;
  logic [2:0]          cand_s;

  // Largest shift 0..4 keeping the shifted peak under the target; the
  // loop keeps the last shift that still fits, 0 if none does.
  function automatic logic [2:0] calc_cand(input logic [W-1:0] pk);
    logic [W+3:0] ext;
    logic [2:0]   c;
    c = 3'd0;
    for (int s = 0; s <= 4; s++) begin
      ext = {4'd0, pk} << s;
      if (ext < TARGET_LIM) begin
        c = 3'(s);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  rx_gain_peak_det #(.IQ_DATA_WIDTH(W)) u_peak (
    .sample (sample_in),
    .peak   (peak_s)
  );

  assign acc_max_s = (peak_s > acc_r) ? peak_s : acc_r;
  assign cand_s    = calc_cand(peak_last_r);

  // Sticky overload: set in any state, set beats clear.
  always_comb begin
    overload_n = overload_r;
    if (sample_valid && (peak_s == FULL)) begin
      overload_n = 1'b1;
    end else if (overload_clr) begin
      overload_n = 1'b0;
    end else begin
      overload_n = overload_r;
    end
  end

  // Next-state and datapath: enable=0 beats freeze beats the window flow.
  always_comb begin
    state_n       = state_r;
    bb_gain_n     = bb_gain_r;
    gain_change_n = 1'b0;
    peak_last_n   = peak_last_r;
    acc_n         = acc_r;
    cnt_n         = cnt_r;
    up_cnt_n      = up_cnt_r;
    if (!enable) begin
      state_n   = IDLE;
      bb_gain_n = clamp_gain(manual_gain);
      acc_n     = '0;
      cnt_n     = '0;
      up_cnt_n  = '0;
    end else if (freeze) begin
      // Partial window and pending up-requests are dropped; gain held.
      state_n  = FROZEN;
      acc_n    = '0;
      cnt_n    = '0;
      up_cnt_n = '0;
    end else begin
      case (state_r)
        IDLE, FROZEN: begin
          state_n  = MEASURE;
          acc_n    = '0;
          cnt_n    = '0;
          up_cnt_n = '0;
        end
        MEASURE: begin
          if (sample_valid) begin
            if (cnt_r == CNT_LAST) begin
              peak_last_n = acc_max_s;
              acc_n       = '0;
              cnt_n       = '0;
              state_n     = DECIDE;
            end else begin
              acc_n = acc_max_s;
              cnt_n = cnt_r + CNT_ONE;
            end
          end else begin
            acc_n = acc_r;
          end
        end
        DECIDE: begin
          state_n = MEASURE;
          // The next window has already started; keep accepting samples.
          if (sample_valid) begin
            acc_n = acc_max_s;
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            acc_n = acc_r;
          end
          if (cand_s < bb_gain_r) begin
            bb_gain_n     = cand_s;
            up_cnt_n      = '0;
            gain_change_n = 1'b1;
          end else if (cand_s > bb_gain_r) begin
            if (up_cnt_r == UP_LAST) begin
              bb_gain_n     = bb_gain_r + 3'd1;
              up_cnt_n      = '0;
              gain_change_n = 1'b1;
            end else begin
              up_cnt_n = up_cnt_r + UP_ONE;
            end
          end else begin
            up_cnt_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge acc_clk or posedge acc_rst) begin
    if (acc_rst) begin
      state_r       <= IDLE;
      bb_gain_r     <= 3'd0;
      gain_change_r <= 1'b0;
      peak_last_r   <= '0;
      overload_r    <= 1'b0;
      acc_r         <= '0;
      cnt_r         <= '0;
      up_cnt_r      <= '0;
    end else begin
      state_r       <= state_n;
      bb_gain_r     <= bb_gain_n;
      gain_change_r <= gain_change_n;
      peak_last_r   <= peak_last_n;
      overload_r    <= overload_n;
      acc_r         <= acc_n;
      cnt_r         <= cnt_n;
      up_cnt_r      <= up_cnt_n;
    end
  end

  assign bb_gain     = bb_gain_r;
  assign gain_change = gain_change_r;
  assign peak_last   = peak_last_r;
  assign overload    = overload_r;

endmodule

// File: tb/tb_rx_bb_gain_ctrl.sv
// Directed self-checking bench for rx_bb_gain_ctrl (W=16, 64-sample windows,
// TARGET_MSB=14, UP_HOLD=4). Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_rx_bb_gain_ctrl;
  import rx_bb_gain_pkg::*;

  logic        acc_clk = 1'b0;
  logic        acc_rst;
  logic        enable;
  logic [2:0]  manual_gain;
  logic        freeze;
  logic [63:0] sample_in;
  logic        sample_valid;
  logic        overload_clr;
  logic [2:0]  bb_gain;
  logic        gain_change;
  logic [15:0] peak_last;
  logic        overload;

  int tests = 0;
  int fails = 0;

  rx_bb_gain_ctrl #(
    .IQ_DATA_WIDTH(16), .WIN_LOG2(6), .TARGET_MSB(14), .UP_HOLD(4)
  ) dut (
    .acc_clk      (acc_clk),
    .acc_rst      (acc_rst),
    .enable       (enable),
    .manual_gain  (manual_gain),
    .freeze       (freeze),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .overload_clr (overload_clr),
    .bb_gain      (bb_gain),
    .gain_change  (gain_change),
    .peak_last    (peak_last),
    .overload     (overload)
  );

  always #5 acc_clk = ~acc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge acc_clk);
    #1;
  endtask

  // Lanes alternate +mag / -mag so the magnitude path sees both signs.
  task automatic run(input int n, input logic [15:0] mag);
    logic [15:0] neg;
    neg = -mag;
    for (int i = 0; i < n; i++) begin
      sample_in    = {neg, mag, neg, mag};
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic one(input logic [15:0] l3, input logic [15:0] l2,
                     input logic [15:0] l1, input logic [15:0] l0);
    sample_in    = {l3, l2, l1, l0};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    acc_rst = 1'b1; enable = 1'b0; manual_gain = 3'd0; freeze = 1'b0;
    sample_in = 64'd0; sample_valid = 1'b0; overload_clr = 1'b0;
    tick(); tick();
    check("rst_gain", 32'(bb_gain), 32'd0);
    check("rst_gc", 32'(gain_change), 32'd0);
    check("rst_peak", 32'(peak_last), 32'd0);
    check("rst_ovl", 32'(overload), 32'd0);
    acc_rst = 1'b0;
    tick();

    // 1: four windows at magnitude 1000 -> cand 4, one step up after the 4th.
    enable = 1'b1;
    tick();
    run(255, 16'd1000);
    check("w3_gain", 32'(bb_gain), 32'd0);
    run(1, 16'd1000);
    check("w4_peak", 32'(peak_last), 32'd1000);
    check("w4_gain_n", 32'(bb_gain), 32'd0);
    check("w4_gc_n", 32'(gain_change), 32'd0);
    tick();
    check("w4_gain_n2", 32'(bb_gain), 32'd1);
    check("w4_gc_n2", 32'(gain_change), 32'd1);
    tick();
    check("w4_gc_off", 32'(gain_change), 32'd0);
    check("w4_gain_hold", 32'(bb_gain), 32'd1);

    // 2: gain 4 (manual), then one 9000 sample in a window -> drop to 0.
    enable = 1'b0; manual_gain = 3'd4;
    tick();
    check("man4_gain", 32'(bb_gain), 32'd4);
    check("man4_gc", 32'(gain_change), 32'd0);
    enable = 1'b1;
    tick();
    run(20, 16'd100);
    one(16'd100, 16'd100, -16'd9000, 16'd100);
    run(43, 16'd100);
    check("big_peak", 32'(peak_last), 32'd9000);
    check("big_gain_n", 32'(bb_gain), 32'd4);
    tick();
    check("big_gain_n2", 32'(bb_gain), 32'd0);
    check("big_gc", 32'(gain_change), 32'd1);
    tick();
    check("big_gc_off", 32'(gain_change), 32'd0);

    // 3: three up-requests, then freeze at sample 30 of the 4th window.
    run(192, 16'd1000);
    check("pre_frz_gain", 32'(bb_gain), 32'd0);
    run(30, 16'd1020);
    freeze = 1'b1;
    run(5, 16'd1020);
    check("frz_gain", 32'(bb_gain), 32'd0);
    check("frz_peak", 32'(peak_last), 32'd1000);
    freeze = 1'b0;
    tick();
    run(63, 16'd1010);
    check("post63_peak", 32'(peak_last), 32'd1000);
    run(1, 16'd1010);
    check("post64_peak", 32'(peak_last), 32'd1010);
    tick();
    check("post_w1_gain", 32'(bb_gain), 32'd0);
    check("post_w1_gc", 32'(gain_change), 32'd0);
    run(191, 16'd1000);
    check("post_w4_gain_n", 32'(bb_gain), 32'd0);
    run(1, 16'd1000);
    tick();
    check("post_w4_gain", 32'(bb_gain), 32'd1);
    check("post_w4_gc", 32'(gain_change), 32'd1);
    tick();

    // 4: manual mode, 6 clamps to 4, no gain_change.
    enable = 1'b0; manual_gain = 3'd6;
    tick();
    check("man6_gain", 32'(bb_gain), 32'd4);
    check("man6_gc", 32'(gain_change), 32'd0);
    manual_gain = 3'd2;
    tick();
    check("man2_gain", 32'(bb_gain), 32'd2);
    check("man2_gc", 32'(gain_change), 32'd0);

    // 5: 0x8000 lane -> overload and saturated peak; set beats clear.
    enable = 1'b1;
    tick();
    run(10, 16'd100);
    one(16'd100, 16'd100, 16'h8000, 16'd100);
    check("ovl_set", 32'(overload), 32'd1);
    run(53, 16'd100);
    check("ovl_peak", 32'(peak_last), 32'h7FFF);
    tick();
    check("ovl_drop_gain", 32'(bb_gain), 32'd0);
    overload_clr = 1'b1;
    tick();
    check("ovl_clr", 32'(overload), 32'd0);
    one(16'h8000, 16'd0, 16'd0, 16'd0);
    check("ovl_set_wins", 32'(overload), 32'd1);
    overload_clr = 1'b0;

    // 6: async reset during DECIDE.
    enable = 1'b0; manual_gain = 3'd3;
    tick();
    check("man3_gain", 32'(bb_gain), 32'd3);
    enable = 1'b1;
    tick();
    run(64, 16'd1000);
    check("dec_peak", 32'(peak_last), 32'd1000);
    check("dec_state", 32'(dut.state_r), 32'(DECIDE));
    #1 acc_rst = 1'b1;
    #1;
    check("arst_gain", 32'(bb_gain), 32'd0);
    check("arst_gc", 32'(gain_change), 32'd0);
    check("arst_peak", 32'(peak_last), 32'd0);
    check("arst_ovl", 32'(overload), 32'd0);
    check("arst_state", 32'(dut.state_r), 32'(IDLE));
    tick();
    acc_rst = 1'b0;
    tick();
    check("arst_gc_after", 32'(gain_change), 32'd0);
    check("arst_gain_after", 32'(bb_gain), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
